// File: rtl/instr_queue_pkg.sv
// ----------------------------------------------------------------------------
// instr_queue_pkg
//   Shared definitions for the instruction queue between fetch and decode.
//   COMPRESSED_OPCODE_MASK : low opcode bits that mark a full 32-bit instruction
//   is_compressed()        : 1 when the first halfword starts a 16-bit instruction
// ----------------------------------------------------------------------------
package instr_queue_pkg;

    localparam logic [1:0] COMPRESSED_OPCODE_MASK = 2'b11;

    // Any value other than 2'b11 in the two lowest bits is a compressed opcode.
    function automatic logic is_compressed(input logic [1:0] lowBits);
        return (lowBits & COMPRESSED_OPCODE_MASK) != COMPRESSED_OPCODE_MASK;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// ----------------------------------------------------------------------------
// instr_queue_if
//   Handshake bundle of the instruction queue.
//   Fetch side : InValid, InReady, InInstr, InPC, InFault
//   Decode side: OutValid, OutReady, OutInstr, OutPC, OutCompressed, OutFault
//   Status     : Count (occupied entries)
//   modport slave  : the queue itself
//   modport master : the environment (fetch buffer + decode stage)
// ----------------------------------------------------------------------------
interface instr_queue_if #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 64,
    parameter int WORDLEN = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               InValid;
    logic               InReady;
    logic [WORDLEN-1:0] InInstr;
    logic [XLEN-1:0]    InPC;
    logic               InFault;
    logic               OutValid;
    logic               OutReady;
    logic [WORDLEN-1:0] OutInstr;
    logic [XLEN-1:0]    OutPC;
    logic               OutCompressed;
    logic               OutFault;
    logic [CW-1:0]      Count;

    modport slave (
        input  InValid, InInstr, InPC, InFault, OutReady,
        output InReady, OutValid, OutInstr, OutPC, OutCompressed, OutFault, Count
    );

    modport master (
        output InValid, InInstr, InPC, InFault, OutReady,
        input  InReady, OutValid, OutInstr, OutPC, OutCompressed, OutFault, Count
    );

endinterface

// File: rtl/instr_queue_storage.sv
// ----------------------------------------------------------------------------
// iq_storage
//   DEPTH x WIDTH flop array, one write port and one asynchronous read port.
//   No reset: whether an entry is meaningful is decided by the queue's Count.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
// ----------------------------------------------------------------------------
module iq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 98
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// ----------------------------------------------------------------------------
// instr_queue
//   Decoupling FIFO between the fetch buffer and decode. Each accepted window
//   is classified as compressed or full at push time and delivered in order.
//   clk    : clock
//   reset  : synchronous active-high reset
//   FlushD : synchronous flush, same effect as reset, lower priority
//   q      : instr_queue_if.slave (fetch handshake, decode handshake, Count)
//   Optional feature macro: INSTR_QUEUE_BYPASS_EN
//     defined   -> empty queue with InValid and OutReady passes the window
//                  straight through in the same cycle without storing it
//     undefined -> outputs depend on state only, minimum latency one cycle
// ----------------------------------------------------------------------------
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 64,
    parameter int WORDLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          FlushD,
    instr_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WORDLEN + XLEN + 2;

    logic [PW-1:0]      headPtr_q, headPtr_d;
    logic [PW-1:0]      tailPtr_q, tailPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               empty, full, push, pop, write, bypass;
    logic               inCompressed;
    logic [WORDLEN-1:0] inInstrMasked;
    logic [EW-1:0]      wrEntry, rdEntry;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign q.InReady = ~full;
    assign push      = q.InValid & ~full;
    assign pop       = ~empty & q.OutReady;

`ifdef INSTR_QUEUE_BYPASS_EN
    // Gated by reset/flush so a discarded window never appears at the output.
    assign bypass = empty & q.InValid & q.OutReady & ~FlushD & ~reset;
`else
    assign bypass = 1'b0;
`endif

    assign write = push & ~bypass;

    // A faulting fetch is never reported as compressed, so its word is kept whole.
    assign inCompressed  = ~q.InFault & is_compressed(q.InInstr[1:0]);
    assign inInstrMasked = inCompressed ? {{(WORDLEN-16){1'b0}}, q.InInstr[15:0]}
                                        : q.InInstr;
    assign wrEntry       = {q.InFault, inCompressed, q.InPC, inInstrMasked};

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_storage (
        .clk_i   (clk),
        .we_i    (write),
        .waddr_i (tailPtr_q),
        .wdata_i (wrEntry),
        .raddr_i (headPtr_q),
        .rdata_o (rdEntry)
    );

    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (write) begin
            tailPtr_d = tailPtr_q + PW'(1);
        end
        if (pop) begin
            headPtr_d = headPtr_q + PW'(1);
        end
        case ({write, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // reset and FlushD both discard any push or pop of the same cycle.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        q.OutValid      = 1'b0;
        q.OutInstr      = '0;
        q.OutPC         = '0;
        q.OutCompressed = 1'b0;
        q.OutFault      = 1'b0;
        if (bypass) begin
            q.OutValid      = 1'b1;
            q.OutInstr      = inInstrMasked;
            q.OutPC         = q.InPC;
            q.OutCompressed = inCompressed;
            q.OutFault      = q.InFault;
        end else if (!empty) begin
            q.OutValid      = 1'b1;
            q.OutInstr      = rdEntry[WORDLEN-1:0];
            q.OutPC         = rdEntry[WORDLEN+XLEN-1:WORDLEN];
            q.OutCompressed = rdEntry[EW-2];
            q.OutFault      = rdEntry[EW-1];
        end
    end

    assign q.Count = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_queue
//   Randomized and directed stimulus for instr_queue. The stimulus process
//   decides acceptance from its own occupancy model and queues the expected
//   head contents; a monitor on the falling edge compares the DUT outputs
//   against that queue.
// ----------------------------------------------------------------------------
module tb_instr_queue;

    localparam int DEPTH   = 4;
    localparam int XLEN    = 64;
    localparam int WORDLEN = 32;

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic [WORDLEN-1:0] instr;
        logic               comp;
        logic               fault;
        int                 cyc;
    } exp_t;

    logic clk;
    logic reset;
    logic FlushD;

    instr_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .WORDLEN(WORDLEN)) ifc ();

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .WORDLEN(WORDLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .FlushD (FlushD),
        .q      (ifc.slave)
    );

    exp_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cycleNo    = 0;
    int   modelCount = 0;
    bit   monActive  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to tell entries issued this cycle from entries already stored.
    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cycleNo);
        end
    endtask

    // Reference behaviour: compressed when low bits are not 2'b11 and no fault.
    function automatic exp_t makeExp(input logic [31:0] instr, input logic [63:0] pc,
                                     input logic fault, input int cyc);
        exp_t e;
        e.pc    = pc;
        e.fault = fault;
        e.comp  = (instr[1:0] != 2'b11) && !fault;
        e.instr = e.comp ? (instr & 32'h0000_FFFF) : instr;
        e.cyc   = cyc;
        return e;
    endfunction

    // Drives one cycle of inputs and updates the occupancy model for that cycle.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic f, input logic rdy, input logic fl, input logic rst);
        bit accept, take, thru;
        @(posedge clk);
        #1;
        reset         = rst;
        FlushD        = fl;
        ifc.InValid   = v;
        ifc.InInstr   = instr;
        ifc.InPC      = pc;
        ifc.InFault   = f;
        ifc.OutReady  = rdy;
        if (rst || fl) begin
            modelCount = 0;
        end else begin
            accept = v && (modelCount < DEPTH);
            take   = rdy && (modelCount > 0);
            thru   = 0;
`ifdef INSTR_QUEUE_BYPASS_EN
            thru   = (modelCount == 0) && v && rdy;
`endif
            if (accept) expQ.push_back(makeExp(instr, pc, f, cycleNo));
            if (!thru) modelCount = modelCount + int'(accept) - int'(take);
        end
    endtask

    // Monitor: compare head, InReady and Count against the scoreboard.
    always @(negedge clk) begin
        int   stored;
        bit   expValid;
        exp_t h;
        if (monActive) begin
            stored = 0;
            foreach (expQ[i]) if (expQ[i].cyc < cycleNo) stored++;
            expValid = (stored > 0);
`ifdef INSTR_QUEUE_BYPASS_EN
            if (stored == 0 && ifc.InValid && ifc.OutReady && !FlushD && !reset && expQ.size() > 0)
                expValid = 1;
`endif
            checkOutput("OutValid", 64'(ifc.OutValid), 64'(expValid));
            checkOutput("InReady", 64'(ifc.InReady), 64'(stored != DEPTH));
            checkOutput("Count", 64'(ifc.Count), 64'(stored));
            if (expValid) begin
                h = expQ[0];
                checkOutput("OutPC", ifc.OutPC, h.pc);
                checkOutput("OutInstr", 64'(ifc.OutInstr), 64'(h.instr));
                checkOutput("OutCompressed", 64'(ifc.OutCompressed), 64'(h.comp));
                checkOutput("OutFault", 64'(ifc.OutFault), 64'(h.fault));
            end else begin
                checkOutput("OutPC_empty", ifc.OutPC, 64'h0);
                checkOutput("OutInstr_empty", 64'(ifc.OutInstr), 64'h0);
                checkOutput("OutFlags_empty", 64'({ifc.OutCompressed, ifc.OutFault}), 64'h0);
            end
            if (reset || FlushD) expQ.delete();
            else if (expValid && ifc.OutReady) void'(expQ.pop_front());
        end
    end

    initial begin
        logic [31:0] rInstr;
        reset        = 1'b1;
        FlushD       = 1'b0;
        ifc.InValid  = 1'b0;
        ifc.InInstr  = '0;
        ifc.InPC     = '0;
        ifc.InFault  = 1'b0;
        ifc.OutReady = 1'b0;
        @(posedge clk);
        #1;
        monActive = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] single full window and compressed window");
        applyStimulus(1, 32'h0000_0013, 64'h1000, 0, 0, 0, 0);
        applyStimulus(1, 32'hABCD_4501, 64'h1004, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fill past capacity then drain in order");
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0000_0033, 64'h3000 + 64'(4 * i), 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("[TB] push and pop on a full queue, then flush at three entries");
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h0000_0093, 64'h4000 + 64'(4 * i), 0, 0, 0, 0);
        applyStimulus(1, 32'h0000_0093, 64'h4100, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h0000_0093, 64'h4200, 0, 1, 1, 0);
        applyStimulus(1, 32'h0000_0013, 64'h2000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] faulting window looking compressed");
        applyStimulus(1, 32'hFFFF_0001, 64'h5000, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("[TB] steady push/pop across pointer wrap");
        applyStimulus(1, 32'h0000_0013, 64'h6000, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(1, 32'h0000_0013, 64'h6000 + 64'(4 * i), 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("[TB] empty queue with push and ready together");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h0000_4505, 64'h7000 + 64'(2 * i), 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rInstr = $urandom;
            applyStimulus($urandom_range(0, 3) != 0, rInstr, {$urandom, $urandom},
                          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
